traffic_light_ctrl: RTL and testbench

//  Parametrised two-road (NS/EW) traffic-light sequencer with an internal 1-tick/s divider, per-phase countdown
//  and night flash mode. Outputs raw lamp vectors plus phase/countdown, which drive the 7-seg and dot-matrix displayers.

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/traffic_light_ctrl_tick_gen.sv | 43 ++++
 rtl/traffic_light_ctrl.sv | 165 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the two-road traffic-light sequencer.
//   phase_t      : phase code driven on the controller's phase output
//   LAMP_*       : lamp patterns {red,yellow,green} for one road
//   nextPhase()  : fixed rotation order of the normal (non-flash) phases
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Normal rotation; FLASH is entered and left explicitly by the controller,
  // so anything unexpected simply restarts the rotation at ALL_RED_A.
  function automatic phase_t nextPhase(input phase_t p);
    phase_t n;
    case (p)
      ALL_RED_A: n = NS_GREEN;
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALL_RED_B;
      ALL_RED_B: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      default:   n = ALL_RED_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divides the system clock down to a one-cycle pulse at TICK_HZ.
// Ports:
//   i_clock : system clock
//   i_reset : asynchronous active-high reset (clears the divider)
//   o_tick  : one-cycle pulse, high for the cycle the divider wraps to 0
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_count;
  logic         r_tick;

  // Divider counts 0..DIV-1. The pulse is registered together with the wrap,
  // so it is high exactly while the counter reads 0 after a wrap, and never
  // in the cycles straight after reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == LAST) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + W'(1);
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
// Two-road (NS/EW) traffic-light sequencer with all-red clearance, per-phase
// countdown, night flash mode and optional pedestrian request.
// Optional feature macro: TRAFFIC_PED_REQ_EN (pedestrian latch and walk lamp).
// Ports:
//   FPGA_clock : system clock
//   reset      : asynchronous active-high reset
//   night_mode : level, 1 requests flash mode (taken at end of an all-red)
//   ped_req    : pedestrian button (ignored unless TRAFFIC_PED_REQ_EN)
//   phase      : current phase code (traffic_pkg::phase_t)
//   ns_light   : NS lamps {red,yellow,green}
//   ew_light   : EW lamps {red,yellow,green}
//   count_down : ticks remaining in the current phase
//   tick       : one-cycle pulse at TICK_HZ
//   ped_walk   : pedestrian walk lamp
// -----------------------------------------------------------------------------
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int GREEN_S     = 9,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int PED_SHORT_S = 2,
  parameter int CNT_W       = 4
) (
  input  logic             FPGA_clock,
  input  logic             reset,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic [2:0]       phase,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] count_down,
  output logic             tick,
  output logic             ped_walk
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_S - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_SHORT_S - 1);

  function automatic logic [CNT_W-1:0] loadFor(input phase_t p);
    logic [CNT_W-1:0] v;
    case (p)
      NS_GREEN, EW_GREEN:   v = GREEN_LD;
      NS_YELLOW, EW_YELLOW: v = YELLOW_LD;
      default:              v = ALLRED_LD;
    endcase
    return v;
  endfunction

  phase_t           r_phase, w_nextPhase;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             r_toggle, w_nextToggle;
  logic             w_tick;
  logic             w_isGreen;
  logic             w_isAllRed;
  logic             w_pedLatched;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tickGen (
    .i_clock(FPGA_clock),
    .i_reset(reset),
    .o_tick (w_tick)
  );

  assign w_isGreen  = (r_phase == NS_GREEN) || (r_phase == EW_GREEN);
  assign w_isAllRed = (r_phase == ALL_RED_A) || (r_phase == ALL_RED_B);

`ifdef TRAFFIC_PED_REQ_EN
  logic r_ped, w_nextPed;

  // A press is remembered until the next all-red has been served; presses
  // during flash mode are dropped since no clearance phase is running.
  always_comb begin
    w_nextPed = r_ped;
    if (ped_req && (r_phase != FLASH)) w_nextPed = 1'b1;
    if (w_tick && w_isAllRed && (r_cnt == '0)) w_nextPed = 1'b0;
  end

  // Pedestrian latch register.
  always_ff @(posedge FPGA_clock or posedge reset) begin
    if (reset) r_ped <= 1'b0;
    else       r_ped <= w_nextPed;
  end

  assign w_pedLatched = r_ped;
`else
  logic w_unusedPedReq;
  assign w_unusedPedReq = ped_req;
  assign w_pedLatched   = 1'b0;
`endif

  // Phase, countdown and flash toggle only move on a tick. A phase ends on
  // the tick that finds its count already at 0, so it lasts exactly its
  // duration in ticks. Night mode is only honoured when an all-red expires,
  // which guarantees a green or yellow is never cut short.
  always_comb begin
    w_nextPhase  = r_phase;
    w_nextCnt    = r_cnt;
    w_nextToggle = r_toggle;
    if (w_tick) begin
      if (r_phase == FLASH) begin
        w_nextToggle = ~r_toggle;
        if (!night_mode) begin
          w_nextPhase  = ALL_RED_A;
          w_nextCnt    = ALLRED_LD;
          w_nextToggle = 1'b0;
        end
      end else if (r_cnt != '0) begin
        if (w_isGreen && w_pedLatched && (r_cnt > PED_LD)) w_nextCnt = PED_LD;
        else                                               w_nextCnt = r_cnt - CNT_W'(1);
      end else if (w_isAllRed && night_mode) begin
        w_nextPhase  = FLASH;
        w_nextCnt    = '0;
        w_nextToggle = 1'b1;
      end else begin
        w_nextPhase = nextPhase(r_phase);
        w_nextCnt   = loadFor(w_nextPhase);
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge FPGA_clock or posedge reset) begin
    if (reset) begin
      r_phase  <= ALL_RED_A;
      r_cnt    <= ALLRED_LD;
      r_toggle <= 1'b0;
    end else begin
      r_phase  <= w_nextPhase;
      r_cnt    <= w_nextCnt;
      r_toggle <= w_nextToggle;
    end
  end

  // Lamp decode straight from state, so reset shows all-red immediately.
  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    case (r_phase)
      NS_GREEN:  ns_light = LAMP_G;
      NS_YELLOW: ns_light = LAMP_Y;
      EW_GREEN:  ew_light = LAMP_G;
      EW_YELLOW: ew_light = LAMP_Y;
      FLASH: begin
        ns_light = r_toggle ? LAMP_Y : LAMP_OFF;
        ew_light = r_toggle ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign phase      = r_phase;
  assign count_down = r_cnt;
  assign tick       = w_tick;
  assign ped_walk   = w_pedLatched && w_isAllRed;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
// Scoreboard bench for traffic_light_ctrl at CLK_HZ=10, TICK_HZ=1.
// The stimulus process pushes the expected post-tick state for each upcoming
// tick; the monitor pops one entry on the cycle after every tick pulse.
// Expectations for the pedestrian run follow TRAFFIC_PED_REQ_EN.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [3:0] cnt;
    logic       walk;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       nightMode = 1'b0;
  logic       pedReq = 1'b0;
  logic [2:0] phase;
  logic [2:0] nsLight;
  logic [2:0] ewLight;
  logic [3:0] countDown;
  logic       tick;
  logic       pedWalk;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   relCyc = 0;
  int   absCyc = 0;
  int   ticksSeen = 0;
  int   firstTickCyc = 0;
  int   lastTickCyc = 0;
  logic prevTick = 1'b0;
  logic firstTickPending = 1'b0;

  traffic_light_ctrl #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .GREEN_S    (9),
    .YELLOW_S   (3),
    .ALLRED_S   (1),
    .PED_SHORT_S(2),
    .CNT_W      (4)
  ) dut (
    .FPGA_clock(clock),
    .reset     (reset),
    .night_mode(nightMode),
    .ped_req   (pedReq),
    .phase     (phase),
    .ns_light  (nsLight),
    .ew_light  (ewLight),
    .count_down(countDown),
    .tick      (tick),
    .ped_walk  (pedWalk)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Cycle counters: relCyc counts rising edges since the last reset release.
  always @(posedge clock) begin
    absCyc = absCyc + 1;
    if (reset) relCyc = 0;
    else       relCyc = relCyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] nsLamp(input phase_t p);
    case (p)
      NS_GREEN:  return LAMP_G;
      NS_YELLOW: return LAMP_Y;
      default:   return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ewLamp(input phase_t p);
    case (p)
      EW_GREEN:  return LAMP_G;
      EW_YELLOW: return LAMP_Y;
      default:   return LAMP_R;
    endcase
  endfunction

  // Push one expected post-tick state per count value from hi down to lo.
  task automatic pushRun(input phase_t p, input int hi, input int lo, input logic walk);
    for (int c = hi; c >= lo; c--) begin
      exp_t e;
      e.ph   = p;
      e.ns   = nsLamp(p);
      e.ew   = ewLamp(p);
      e.cnt  = 4'(c);
      e.walk = walk;
      expQ.push_back(e);
    end
  endtask

  task automatic pushFlash(input logic [2:0] lamps);
    exp_t e;
    e.ph   = FLASH;
    e.ns   = lamps;
    e.ew   = lamps;
    e.cnt  = 4'd0;
    e.walk = 1'b0;
    expQ.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every pushed expectation.
  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL drain timeout: got %0d pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic night, input logic pulsePed);
    nightMode = night;
    if (pulsePed) begin
      pedReq = 1'b1;
      @(negedge clock);
      pedReq = 1'b0;
    end
  endtask

  // Monitor: one negedge after a tick pulse the DUT state has advanced, so
  // that is where the next expectation is compared.
  always @(negedge clock) begin
    if (reset) begin
      prevTick = 1'b0;
    end else begin
      if (prevTick && expQ.size() != 0) begin
        exp_t e;
        exp_t act;
        e = expQ.pop_front();
        act = {phase, nsLight, ewLight, countDown, pedWalk};
        vectors = vectors + 1;
        if (act !== e) begin
          miscompares = miscompares + 1;
          $display("[TB] FAIL tick%0d ph/ns/ew/cnt/walk: got %0d/%03b/%03b/%0d/%0d, expected %0d/%03b/%03b/%0d/%0d",
                   ticksSeen, act.ph, act.ns, act.ew, act.cnt, act.walk,
                   e.ph, e.ns, e.ew, e.cnt, e.walk);
        end
      end
      prevTick = tick;
      if (tick) begin
        ticksSeen = ticksSeen + 1;
        lastTickCyc = absCyc;
        if (ticksSeen == 1) firstTickCyc = absCyc;
        if (firstTickPending) begin
          firstTickPending = 1'b0;
          checkOutput("first tick latency", relCyc, 10);
        end
      end
    end
  end

  // Check the whole output set against the reset values.
  task automatic checkResetState(input string tag);
    checkOutput({tag, " phase"}, phase, ALL_RED_A);
    checkOutput({tag, " ns"}, nsLight, LAMP_R);
    checkOutput({tag, " ew"}, ewLight, LAMP_R);
    checkOutput({tag, " count"}, countDown, 0);
    checkOutput({tag, " tick"}, tick, 0);
    checkOutput({tag, " walk"}, pedWalk, 0);
  endtask

  // Directed sequence: reset, full cycle, night flash, pedestrian, async reset.
  initial begin
    repeat (2) @(negedge clock);
    checkResetState("reset");
    firstTickPending = 1'b1;
    reset = 1'b0;

    $display("[TB] full cycle");
    pushRun(NS_GREEN, 8, 0, 0);
    pushRun(NS_YELLOW, 2, 0, 0);
    pushRun(ALL_RED_B, 0, 0, 0);
    pushRun(EW_GREEN, 8, 0, 0);
    pushRun(EW_YELLOW, 2, 0, 0);
    pushRun(ALL_RED_A, 0, 0, 0);
    pushRun(NS_GREEN, 8, 8, 0);
    waitDrain(400);
    checkOutput("tick count", ticksSeen, 27);
    checkOutput("cycle period", lastTickCyc - firstTickCyc, 260);

    $display("[TB] night mode");
    applyStimulus(1'b1, 1'b0);
    pushRun(NS_GREEN, 7, 0, 0);
    pushRun(NS_YELLOW, 2, 0, 0);
    pushRun(ALL_RED_B, 0, 0, 0);
    pushFlash(LAMP_Y);
    waitDrain(300);
    applyStimulus(1'b1, 1'b1);
    pushFlash(LAMP_OFF);
    pushFlash(LAMP_Y);
    waitDrain(40);
    applyStimulus(1'b0, 1'b0);
    pushRun(ALL_RED_A, 0, 0, 0);
    pushRun(NS_GREEN, 8, 7, 0);
    waitDrain(40);

    $display("[TB] pedestrian request");
    applyStimulus(1'b0, 1'b1);
`ifdef TRAFFIC_PED_REQ_EN
    pushRun(NS_GREEN, 1, 0, 0);
    pushRun(NS_YELLOW, 2, 0, 0);
    pushRun(ALL_RED_B, 0, 0, 1);
`else
    pushRun(NS_GREEN, 6, 0, 0);
    pushRun(NS_YELLOW, 2, 0, 0);
    pushRun(ALL_RED_B, 0, 0, 0);
`endif
    pushRun(EW_GREEN, 8, 0, 0);
    pushRun(EW_YELLOW, 2, 2, 0);
    waitDrain(300);

    $display("[TB] async reset mid EW_YELLOW");
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 checkResetState("async reset");
    expQ.delete();
    firstTickPending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("tick held in reset", tick, 0);
    end
    reset = 1'b0;
    pushRun(NS_GREEN, 8, 8, 0);
    waitDrain(40);
    if (firstTickPending) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL first tick after reset: got none, expected one");
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
